movimenta_asteroides_e_tiros: RTL and testbench
===============================================

# movimenta_asteroides_e_tiros

Movement engine for the AstroGenius main game loop. It answers the main game control unit's `inicia_movimentacao_asteroides_e_tiros` / `fim_movimentacao_asteroides_e_tiros` handshake. On each pass it advances every active asteroid one cell toward the ship, then every active shot one cell along its direction. It reads and rewrites the asteroid and shot tables held in external synchronous RAMs, and pulses `perde_vida` when an asteroid reaches the ship.

## Interface

Parameters:
- `N_AST`, default 8: number of asteroid table entries.
- `N_TIRO`, default 4: number of shot table entries.
- `COORD_W`, default 4: coordinate width; the grid is 0..2^COORD_W-1 on each axis.
- `NAVE_X`, default 8: ship x position.
- `NAVE_Y`, default 8: ship y position.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start a pass. Driven by the main UC's `inicia_movimentacao_asteroides_e_tiros`.
- `pronto` out 1: one-cycle pulse when the pass is complete. Feeds `fim_movimentacao_asteroides_e_tiros`.
- `ast_addr` out clog2(N_AST): asteroid RAM address.
- `ast_rdata` in 1+2·COORD_W: packed as {valid, x, y}.
- `ast_wdata` out 1+2·COORD_W: asteroid write data.
- `ast_we` out 1: asteroid RAM write enable.
- `tiro_addr` out clog2(N_TIRO): shot RAM address.
- `tiro_rdata` in 3+2·COORD_W: packed as {valid, dir[1:0], x, y}.
- `tiro_wdata` out 3+2·COORD_W: shot write data.
- `tiro_we` out 1: shot RAM write enable.
- `perde_vida` out 1: one-cycle pulse per asteroid–ship collision.
- `db_estado_movimentacao` out 5: current state code, for debug.

## Operation

- **RAM model:** both RAMs are synchronous. Read data is valid the cycle after the address is presented, and writes take effect at the clock edge where `we`=1.
- **States and codes:**
  - IDLE=0, LE_AST=1, ESPERA_AST=2, ESCREVE_AST=3.
  - LE_TIRO=4, ESPERA_TIRO=5, ESCREVE_TIRO=6, FIM=7.
- **Transitions:**
  - IDLE → LE_AST when `iniciar`=1.
  - Asteroid loop: LE_AST → ESPERA_AST → ESCREVE_AST → LE_AST with the index incremented. After the last index, ESCREVE_AST goes to LE_TIRO.
  - Shot loop: the same pattern over LE_TIRO, ESPERA_TIRO, ESCREVE_TIRO. After the last index, ESCREVE_TIRO goes to FIM.
  - FIM → IDLE unconditionally.
- **Index and address:**
  - The index resets to 0 on entry to each loop.
  - `*_addr` equals the current index for all three states of that entry.
- **ESPERA_\*:** the read data is captured and the new entry is computed into a register.
- **ESCREVE_\*:** `*_we`=1 and `*_wdata` = the computed entry. Every entry is written back, including invalid ones, which are written unchanged.
- **Asteroid step (valid entries only):**
  - x moves ±1 toward `NAVE_X` unless x already equals `NAVE_X`. y moves the same way toward `NAVE_Y`. Both axes move in the same cycle.
  - If the new (x,y) equals (`NAVE_X`,`NAVE_Y`), the entry is written with valid=0 and x,y set to the new values. `perde_vida` is asserted during that ESCREVE_AST cycle.
- **Shot step (valid entries only):**
  - dir 00 → x+1, 01 → x−1, 10 → y+1, 11 → y−1.
  - A shot stepping off the grid (x=max with dir 00, x=0 with 01, y=max with 10, y=0 with 11) is written with valid=0 and its coordinates unchanged. There is no wrap-around.
- **`iniciar` handling:** ignored in every state except IDLE. If `iniciar` is high in FIM, the next pass starts only after IDLE has been sampled.
- **Multiple collisions:** several collisions in one pass produce one `perde_vida` pulse each, on separate cycles.
- **Outputs:** `pronto` is 1 only in FIM. `perde_vida` and both write enables are 0 in all other states.

## Timing

- **Reset:** all outputs are 0 (`pronto`, `*_we`, `*_addr`, `*_wdata`, `perde_vida`, `db_estado_movimentacao`). The state is IDLE and the index is 0.
- **Reset mid-pass:** returns to IDLE at the next edge without a `pronto` pulse. Any RAM write already committed stays. No further writes occur.
- **Entry timing:** each entry takes exactly 3 cycles.
- **Latency:** with `iniciar` sampled at edge 0, FIM (`pronto`=1) occupies cycle 3·(N_AST+N_TIRO)+1. IDLE follows.
- **Write timing:** the write for entry i occurs at the end of that entry's ESCREVE cycle. The read of entry i+1 is issued the following cycle, so there are no read-after-write hazards.

## Configuration

- Macro: `MOVIMENTA_COLISAO_NAVE_EN`.
- **Defined:** collision detection as described above, including invalidation and the `perde_vida` pulse.
- **Undefined:**
  - An asteroid reaching the ship position stays valid and holds there on later passes.
  - `perde_vida` is tied to 0.
  - All timing is unchanged.

## Test plan

All scenarios use N_AST=2, N_TIRO=2, COORD_W=4, NAVE=(8,8).

- **Reset:** hold `reset` for 2 cycles → all outputs 0, `db_estado_movimentacao`=0. `iniciar` pulsed during reset → no activity.
- **Basic pass:** ast0={1,3,12}, ast1 invalid; tiro0={1,00,5,5}, tiro1 invalid; pulse `iniciar` → `pronto` exactly in cycle 13 for one cycle. RAM afterwards holds ast0={1,4,11}, tiro0={1,00,6,5}, and the invalid entries unchanged.
- **Collision:** ast0={1,7,9} → written {0,8,8}, `perde_vida` high for one cycle during ESCREVE_AST of index 0. With the macro undefined: written {1,8,8} and `perde_vida`=0.
- **Shot boundaries:**
  - tiro0={1,01,0,3} → written {0,01,0,3}.
  - tiro1={1,10,4,15} → written {0,10,4,15}.
- **Busy and back-to-back:** `iniciar` held high for 20 cycles → exactly one `pronto` per pass. A second pass starts after IDLE and moves ast0 a second step.
- **Reset mid-pass:** assert `reset` in cycle 5 → IDLE next edge, no `pronto`. ast0 keeps the value written in cycle 3, and ast1 is unmodified.

Source files
------------

// File: rtl/movimenta_asteroides_e_tiros.sv
// Movement engine for the AstroGenius game loop. On each pass it steps every
// asteroid one cell toward the ship and then every shot one cell along its
// direction. Both tables are read from and written back to external
// synchronous RAMs, one entry at a time (read, wait, write).
// Optional feature macro: MOVIMENTA_COLISAO_NAVE_EN enables ship collision
// (the asteroid is invalidated and perde_vida pulses). When the macro is not
// defined, an asteroid that reaches the ship stays valid and perde_vida is 0.
module movimenta_asteroides_e_tiros #(
  parameter int N_AST   = 8,
  parameter int N_TIRO  = 4,
  parameter int COORD_W = 4,
  parameter int NAVE_X  = 8,
  parameter int NAVE_Y  = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar,
  output logic                         pronto,
  output logic [$clog2(N_AST)-1:0]     ast_addr,
  input  logic [2*COORD_W:0]           ast_rdata,
  output logic [2*COORD_W:0]           ast_wdata,
  output logic                         ast_we,
  output logic [$clog2(N_TIRO)-1:0]    tiro_addr,
  input  logic [2*COORD_W+2:0]         tiro_rdata,
  output logic [2*COORD_W+2:0]         tiro_wdata,
  output logic                         tiro_we,
  output logic                         perde_vida,
  output logic [4:0]                   db_estado_movimentacao
);

  localparam int AA_W   = $clog2(N_AST);
  localparam int TA_W   = $clog2(N_TIRO);
  localparam int IDX_W  = (AA_W > TA_W) ? AA_W : TA_W;
  localparam int AST_W  = 2 * COORD_W + 1;
  localparam int TIRO_W = 2 * COORD_W + 3;

  localparam logic [COORD_W-1:0] NX    = COORD_W'(NAVE_X);
  localparam logic [COORD_W-1:0] NY    = COORD_W'(NAVE_Y);
  localparam logic [COORD_W-1:0] C_MAX = '1;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LE_AST       = 3'd1,
    ESPERA_AST   = 3'd2,
    ESCREVE_AST  = 3'd3,
    LE_TIRO      = 3'd4,
    ESPERA_TIRO  = 3'd5,
    ESCREVE_TIRO = 3'd6,
    FIM          = 3'd7
  } estado_t;

  estado_t            state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TIRO_W-1:0]  ent_q;
  logic [AST_W-1:0]   ast_next;
  logic [TIRO_W-1:0]  tiro_next;
  logic               col_next;

  // One step of a coordinate toward a target, holding once it is reached.
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] alvo
  );
    if (v < alvo)      return v + COORD_W'(1);
    else if (v > alvo) return v - COORD_W'(1);
    else               return v;
  endfunction

  // State and entry index register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: three cycles per entry, asteroid loop then shot loop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (iniciar) state_d = LE_AST;
      end
      LE_AST:      state_d = ESPERA_AST;
      ESPERA_AST:  state_d = ESCREVE_AST;
      ESCREVE_AST: begin
        if (idx_q == IDX_W'(N_AST - 1)) begin
          state_d = LE_TIRO;
          idx_d   = '0;
        end else begin
          state_d = LE_AST;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      LE_TIRO:     state_d = ESPERA_TIRO;
      ESPERA_TIRO: state_d = ESCREVE_TIRO;
      ESCREVE_TIRO: begin
        if (idx_q == IDX_W'(N_TIRO - 1)) begin
          state_d = FIM;
          idx_d   = '0;
        end else begin
          state_d = LE_TIRO;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      FIM: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Asteroid step: both axes move toward the ship in the same cycle.
  always_comb begin
    logic [COORD_W-1:0] ax, ay;
    ax       = step_axis(ast_rdata[2*COORD_W-1:COORD_W], NX);
    ay       = step_axis(ast_rdata[COORD_W-1:0], NY);
    ast_next = ast_rdata;
    col_next = 1'b0;
    if (ast_rdata[AST_W-1]) begin
      col_next = (ax == NX) && (ay == NY);
`ifdef MOVIMENTA_COLISAO_NAVE_EN
      ast_next = {~col_next, ax, ay};
`else
      ast_next = {1'b1, ax, ay};
`endif
    end
  end

  // Shot step: a shot leaving the grid is invalidated in place, no wrap.
  always_comb begin
    logic [1:0]         dir;
    logic [COORD_W-1:0] tx, ty;
    logic               fora;
    dir       = tiro_rdata[TIRO_W-2:TIRO_W-3];
    tx        = tiro_rdata[2*COORD_W-1:COORD_W];
    ty        = tiro_rdata[COORD_W-1:0];
    fora      = 1'b0;
    tiro_next = tiro_rdata;
    case (dir)
      2'b00: if (tx == C_MAX) fora = 1'b1; else tx = tx + COORD_W'(1);
      2'b01: if (tx == '0)    fora = 1'b1; else tx = tx - COORD_W'(1);
      2'b10: if (ty == C_MAX) fora = 1'b1; else ty = ty + COORD_W'(1);
      default: if (ty == '0)  fora = 1'b1; else ty = ty - COORD_W'(1);
    endcase
    if (tiro_rdata[TIRO_W-1]) begin
      if (fora) tiro_next = {1'b0, tiro_rdata[TIRO_W-2:0]};
      else      tiro_next = {1'b1, dir, tx, ty};
    end
  end

  // Capture the computed entry while the RAM read data is valid.
  always_ff @(posedge clock) begin
    if (state_q == ESPERA_AST)  ent_q <= TIRO_W'(ast_next);
    if (state_q == ESPERA_TIRO) ent_q <= tiro_next;
  end

`ifdef MOVIMENTA_COLISAO_NAVE_EN
  logic col_q;

  // Remember whether the pending asteroid write is a ship collision.
  always_ff @(posedge clock) begin
    if (reset)                        col_q <= 1'b0;
    else if (state_q == ESPERA_AST)   col_q <= col_next;
  end

  assign perde_vida = (state_q == ESCREVE_AST) && col_q;
`else
  logic unused_col;
  assign unused_col = col_next;
  assign perde_vida = 1'b0;
`endif

  assign ast_we     = (state_q == ESCREVE_AST);
  assign tiro_we    = (state_q == ESCREVE_TIRO);
  assign ast_addr   = (state_q == LE_AST || state_q == ESPERA_AST || ast_we)
                      ? AA_W'(idx_q) : '0;
  assign tiro_addr  = (state_q == LE_TIRO || state_q == ESPERA_TIRO || tiro_we)
                      ? TA_W'(idx_q) : '0;
  assign ast_wdata  = ast_we  ? ent_q[AST_W-1:0] : '0;
  assign tiro_wdata = tiro_we ? ent_q : '0;
  assign pronto     = (state_q == FIM);
  assign db_estado_movimentacao = {2'b00, state_q};

endmodule

// File: tb/tb_movimenta_asteroides_e_tiros.sv
// Scoreboard bench for movimenta_asteroides_e_tiros with 2 asteroids and
// 2 shots on a 16x16 grid, ship at (8,8). RAMs are modelled in the bench.
module tb_movimenta_asteroides_e_tiros;
  localparam int NA = 2;
  localparam int NT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        pronto;
  logic [0:0]  ast_addr;
  logic [8:0]  ast_rdata;
  logic [8:0]  ast_wdata;
  logic        ast_we;
  logic [0:0]  tiro_addr;
  logic [10:0] tiro_rdata;
  logic [10:0] tiro_wdata;
  logic        tiro_we;
  logic        perde_vida;
  logic [4:0]  db_estado_movimentacao;

  movimenta_asteroides_e_tiros #(
    .N_AST(NA), .N_TIRO(NT), .COORD_W(4), .NAVE_X(8), .NAVE_Y(8)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pronto(pronto),
    .ast_addr(ast_addr), .ast_rdata(ast_rdata), .ast_wdata(ast_wdata),
    .ast_we(ast_we), .tiro_addr(tiro_addr), .tiro_rdata(tiro_rdata),
    .tiro_wdata(tiro_wdata), .tiro_we(tiro_we), .perde_vida(perde_vida),
    .db_estado_movimentacao(db_estado_movimentacao)
  );

  always #5 clock = ~clock;

  // RAM models with a bench-side load port
  logic [8:0]  ast_mem [NA];
  logic [10:0] tiro_mem [NT];
  logic [8:0]  ld_ast [NA];
  logic [10:0] ld_tiro [NT];
  logic        ld_en = 1'b0;
  int          ecnt = 0;

  always @(posedge clock) begin
    ecnt <= ecnt + 1;
    if (ld_en) begin
      for (int i = 0; i < NA; i++) ast_mem[i] <= ld_ast[i];
      for (int i = 0; i < NT; i++) tiro_mem[i] <= ld_tiro[i];
    end else begin
      if (ast_we)  ast_mem[ast_addr]   <= ast_wdata;
      if (tiro_we) tiro_mem[tiro_addr] <= tiro_wdata;
    end
    ast_rdata  <= ast_mem[ast_addr];
    tiro_rdata <= tiro_mem[tiro_addr];
  end

  typedef struct packed {
    logic [1:0]  kind;   // 0 asteroid write, 1 shot write, 2 pronto, 3 stray pulse
    logic [1:0]  idx;
    logic [10:0] data;
    logic        perde;
    logic [31:0] cyc;
  } ev_t;

  ev_t         expq [$];
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  sh_ast [NA];
  logic [10:0] sh_tiro [NT];

  // Reference asteroid rule: returns {perde, new entry}
  function automatic logic [9:0] ast_ref(input logic [8:0] e);
    int x, y;
    x = int'(e[7:4]);
    y = int'(e[3:0]);
    if (!e[8]) return {1'b0, e};
    if (x < 8) x = x + 1; else if (x > 8) x = x - 1;
    if (y < 8) y = y + 1; else if (y > 8) y = y - 1;
`ifdef MOVIMENTA_COLISAO_NAVE_EN
    if (x == 8 && y == 8) return {1'b1, 1'b0, x[3:0], y[3:0]};
`endif
    return {1'b0, 1'b1, x[3:0], y[3:0]};
  endfunction

  // Reference shot rule
  function automatic logic [10:0] tiro_ref(input logic [10:0] e);
    int x, y;
    logic [1:0] d;
    d = e[9:8];
    x = int'(e[7:4]);
    y = int'(e[3:0]);
    if (!e[10]) return e;
    case (d)
      2'd0: begin if (x == 15) return {1'b0, e[9:0]}; x = x + 1; end
      2'd1: begin if (x == 0)  return {1'b0, e[9:0]}; x = x - 1; end
      2'd2: begin if (y == 15) return {1'b0, e[9:0]}; y = y + 1; end
      default: begin if (y == 0) return {1'b0, e[9:0]}; y = y - 1; end
    endcase
    return {1'b1, d, x[3:0], y[3:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  // Expected events of one whole pass started at sampling edge e0
  task automatic push_pass(input int e0);
    logic [9:0] r;
    ev_t ev;
    for (int i = 0; i < NA; i++) begin
      r = ast_ref(sh_ast[i]);
      ev = '{kind: 2'd0, idx: 2'(i), data: {2'b00, r[8:0]}, perde: r[9], cyc: 32'(e0 + 3*i + 2)};
      expq.push_back(ev);
      sh_ast[i] = r[8:0];
    end
    for (int i = 0; i < NT; i++) begin
      ev = '{kind: 2'd1, idx: 2'(i), data: tiro_ref(sh_tiro[i]), perde: 1'b0,
             cyc: 32'(e0 + 3*(NA + i) + 2)};
      expq.push_back(ev);
      sh_tiro[i] = ev.data;
    end
    ev = '{kind: 2'd2, idx: 2'd0, data: 11'd0, perde: 1'b0, cyc: 32'(e0 + 3*(NA + NT))};
    expq.push_back(ev);
  endtask

  task automatic load(input logic [8:0] a0, input logic [8:0] a1,
                      input logic [10:0] t0, input logic [10:0] t1);
    ld_ast[0] = a0;  ld_ast[1] = a1;  ld_tiro[0] = t0;  ld_tiro[1] = t1;
    sh_ast[0] = a0;  sh_ast[1] = a1;  sh_tiro[0] = t0;  sh_tiro[1] = t1;
    ld_en = 1'b1;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic start_pass(output int e0);
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    e0 = ecnt;
    iniciar = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100 && expq.size() != 0; k++) @(negedge clock);
    chk({name, "_drain"}, 64'(expq.size()), 64'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_ram(input string name);
    for (int i = 0; i < NA; i++) chk({name, "_ast_ram"}, 64'(ast_mem[i]), 64'(sh_ast[i]));
    for (int i = 0; i < NT; i++) chk({name, "_tiro_ram"}, 64'(tiro_mem[i]), 64'(sh_tiro[i]));
  endtask

  task automatic run_pass(input string name);
    int e0;
    start_pass(e0);
    push_pass(e0);
    drain(name);
    check_ram(name);
  endtask

  initial begin
    fork
      // Monitor: pops one expected event per observed DUT output event
      forever begin
        ev_t act, req;
        @(negedge clock);
        if (ast_we || tiro_we || pronto || perde_vida) begin
          act.kind  = pronto ? 2'd2 : tiro_we ? 2'd1 : ast_we ? 2'd0 : 2'd3;
          act.idx   = pronto ? 2'd0 : tiro_we ? {1'b0, tiro_addr} : {1'b0, ast_addr};
          act.data  = pronto ? 11'd0 : tiro_we ? tiro_wdata : {2'b00, ast_wdata};
          act.perde = perde_vida;
          act.cyc   = 32'(ecnt);
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d idx=%0d data=%h perde=%0d cyc=%0d",
                     act.kind, act.idx, act.data, act.perde, act.cyc);
          end else begin
            req = expq.pop_front();
            if (act !== req) begin
              errors++;
              $display("FAIL event got kind=%0d idx=%0d data=%h perde=%0d cyc=%0d expected kind=%0d idx=%0d data=%h perde=%0d cyc=%0d",
                       act.kind, act.idx, act.data, act.perde, act.cyc,
                       req.kind, req.idx, req.data, req.perde, req.cyc);
            end
          end
        end
      end
      // Stimulus
      begin
        int e0;
        logic [9:0] r;
        ev_t ev;
        // Reset held 2 cycles with iniciar pulsed
        reset = 1'b1;
        iniciar = 1'b1;
        load(9'h0, 9'h0, 11'h0, 11'h0);
        repeat (2) begin
          @(negedge clock);
          chk("reset_outputs", {pronto, ast_we, tiro_we, perde_vida, ast_addr, tiro_addr,
                                ast_wdata, tiro_wdata, db_estado_movimentacao}, 64'd0);
        end
        iniciar = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_after_reset", 64'(db_estado_movimentacao), 64'd0);

        // Basic pass
        load({1'b1, 4'd3, 4'd12}, {1'b0, 4'd2, 4'd2}, {1'b1, 2'b00, 4'd5, 4'd5}, {1'b0, 2'b11, 4'd9, 4'd1});
        run_pass("basic");

        // Collision from (7,9)
        load({1'b1, 4'd7, 4'd9}, {1'b1, 4'd15, 4'd0}, {1'b1, 2'b01, 4'd0, 4'd3}, {1'b1, 2'b10, 4'd4, 4'd15});
        run_pass("collision_and_bounds");

        // Both asteroids collide in one pass; remaining shot boundaries
        load({1'b1, 4'd9, 4'd9}, {1'b1, 4'd8, 4'd7}, {1'b1, 2'b00, 4'd15, 4'd6}, {1'b1, 2'b11, 4'd6, 4'd0});
        run_pass("double_collision");

        // iniciar held 20 cycles: two back-to-back passes
        load({1'b1, 4'd0, 4'd15}, {1'b0, 4'd0, 4'd0}, {1'b1, 2'b10, 4'd3, 4'd3}, {1'b1, 2'b01, 4'd1, 4'd1});
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        e0 = ecnt;
        for (int s = e0; s <= e0 + 19; s += 3*(NA + NT) + 2) push_pass(s);
        repeat (19) @(posedge clock);
        #1;
        iniciar = 1'b0;
        drain("held_iniciar");
        check_ram("held_iniciar");

        // Randomized passes
        for (int n = 0; n < 6; n++) begin
          load({$urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
               {$urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
               {$urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
               {$urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))});
          run_pass("random");
        end

        // Reset in cycle 5 of a pass
        load({1'b1, 4'd3, 4'd12}, {1'b1, 4'd12, 4'd12}, {1'b1, 2'b00, 4'd5, 4'd5}, {1'b1, 2'b00, 4'd1, 4'd1});
        start_pass(e0);
        r = ast_ref(sh_ast[0]);
        ev = '{kind: 2'd0, idx: 2'd0, data: {2'b00, r[8:0]}, perde: r[9], cyc: 32'(e0 + 2)};
        expq.push_back(ev);
        sh_ast[0] = r[8:0];
        for (int k = 0; k < 50 && ecnt < e0 + 4; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midpass_reset_state", 64'(db_estado_movimentacao), 64'd0);
        repeat (20) @(negedge clock);
        chk("midpass_no_more_events", 64'(expq.size()), 64'd0);
        chk("midpass_still_idle", 64'(db_estado_movimentacao), 64'd0);
        check_ram("midpass");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end

endmodule
